// File: rtl/kamikaze_ibus_master.sv
// kamikaze_ibus_master: single-outstanding instruction bus fetch master with flush and timeout
module kamikaze_ibus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] ir_o,
  output logic        memory_ready_o,
  input  logic        branch_i,
  output logic [31:0] ibus_addr_o,
  output logic        ibus_req_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        ibus_err_i,
  output logic        fault_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [31:0] addr_q, data_q;
  logic err_q, done, tmo, fin, cap;
  logic [7:0] cnt_q;
  assign done = ibus_ack_i | ibus_err_i;
  assign tmo = !done && cnt_q == TLAST;
  assign fin = done | tmo;
  always_comb begin
    state_d = state_q;
    cap = 1'b0;
    case (state_q)
      IDLE:  state_d = branch_i ? IDLE : REQ;
      REQ: begin
        cap = fin & !branch_i;
        state_d = fin ? (branch_i ? IDLE : RESP) : (branch_i ? DRAIN : REQ);
      end
      RESP:  state_d = IDLE;
      DRAIN: state_d = fin ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        addr_q <= {pc_i[31:2], 2'b00};
        cnt_q  <= '0;
      end else if ((state_q == REQ || state_q == DRAIN) && !done) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (cap) begin
        data_q <= ibus_ack_i ? ibus_rdata_i : 32'h0;
        err_q  <= !ibus_ack_i;
      end
    end
  end
  assign ibus_req_o     = state_q == REQ || state_q == DRAIN;
  assign ibus_addr_o    = addr_q;
  assign ir_o           = data_q;
  assign memory_ready_o = state_q == RESP && !branch_i;
  assign fault_o        = memory_ready_o && err_q;
endmodule

// File: tb/tb_kamikaze_ibus_master.sv
// tb_kamikaze_ibus_master: scenario tasks with a scoreboard of expected delivered words
module tb_kamikaze_ibus_master;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = '0, rdata = '0;
  logic branch = 1'b0, ack = 1'b0, err = 1'b0;
  logic [31:0] ir, addr;
  logic ready, req, fault;
  int tests = 0, fails = 0;
  logic [32:0] sb[$];

  kamikaze_ibus_master #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .ir_o(ir), .memory_ready_o(ready),
    .branch_i(branch), .ibus_addr_o(addr), .ibus_req_o(req), .ibus_ack_i(ack),
    .ibus_rdata_i(rdata), .ibus_err_i(err), .fault_o(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [32:0] e;
    #3;
    if (ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: got ir=%h fault=%b, required no ready", ir, fault);
      end else begin
        e = sb.pop_front();
        if ({ir, fault} !== e) begin
          fails++;
          $display("FAIL scoreboard: got ir=%h fault=%b, required ir=%h fault=%b", ir, fault, e[32:1], e[0]);
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pc = 32'h100;
    tick;
    tests++;
    if ({req, addr, ir, ready, fault} !== 67'h0) begin
      fails++;
      $display("FAIL reset_state: got req=%b addr=%h ir=%h ready=%b fault=%b, required all 0", req, addr, ir, ready, fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    tick;
    tests++;
    if (req !== 1'b1 || addr !== 32'h100) begin
      fails++;
      $display("FAIL basic_req: got req=%b addr=%h, required 1 00000100", req, addr);
    end
    tick;
    tick;
    ack = 1'b1; rdata = 32'h00A00093; sb.push_back({32'h00A00093, 1'b0});
    tick;
    ack = 1'b0;
    tests++;
    if (ready !== 1'b1 || ir !== 32'h00A00093 || fault !== 1'b0) begin
      fails++;
      $display("FAIL basic_resp: got ready=%b ir=%h fault=%b, required 1 00a00093 0", ready, ir, fault);
    end
    tick;
    pc = 32'h102;
    tests++;
    if (req !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: got req=%b ready=%b, required 0 0", req, ready);
    end
    tick;
    tests++;
    if (req !== 1'b1 || addr !== 32'h100) begin
      fails++;
      $display("FAIL basic_align: got req=%b addr=%h, required 1 00000100", req, addr);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; rdata = 32'hC0DE0000 + 32'(k); sb.push_back({32'hC0DE0000 + 32'(k), 1'b0});
      tick;
      ack = 1'b0;
      tests++;
      if (ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready%0d: got %b, required 1", k, ready);
      end
      tick;
      tests++;
      if (req !== 1'b0 || ready !== 1'b0) begin
        fails++;
        $display("FAIL b2b_idle%0d: got req=%b ready=%b, required 0 0", k, req, ready);
      end
      tick;
      tests++;
      if (req !== 1'b1 || addr !== 32'h100) begin
        fails++;
        $display("FAIL b2b_req%0d: got req=%b addr=%h, required 1 00000100", k, req, addr);
      end
    end
  endtask

  task automatic test_branch;
    branch = 1'b1; pc = 32'h200;
    tick;
    branch = 1'b0;
    tests++;
    if (req !== 1'b1 || addr !== 32'h100) begin
      fails++;
      $display("FAIL drain_hold: got req=%b addr=%h, required 1 00000100", req, addr);
    end
    ack = 1'b1; rdata = 32'hDEADBEEF;
    tick;
    ack = 1'b0;
    tests++;
    if (req !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL drain_done: got req=%b ready=%b, required 0 0", req, ready);
    end
    tick;
    tests++;
    if (req !== 1'b1 || addr !== 32'h200) begin
      fails++;
      $display("FAIL drain_next: got req=%b addr=%h, required 1 00000200", req, addr);
    end
  endtask

  task automatic test_error;
    err = 1'b1; sb.push_back({32'h0, 1'b1});
    tick;
    err = 1'b0;
    tests++;
    if (ready !== 1'b1 || fault !== 1'b1 || ir !== 32'h0) begin
      fails++;
      $display("FAIL error_resp: got ready=%b fault=%b ir=%h, required 1 1 00000000", ready, fault, ir);
    end
    tick;
    tick;
    ack = 1'b1; err = 1'b1; rdata = 32'h00001234; sb.push_back({32'h00001234, 1'b0});
    tick;
    ack = 1'b0; err = 1'b0;
    tests++;
    if (ready !== 1'b1 || fault !== 1'b0 || ir !== 32'h00001234) begin
      fails++;
      $display("FAIL ack_err_both: got ready=%b fault=%b ir=%h, required 1 0 00001234", ready, fault, ir);
    end
    tick;
    tick;
  endtask

  task automatic test_timeout;
    int n = 1;
    sb.push_back({32'h0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!req) break;
      n++;
    end
    tests++;
    if (n !== 4 || ready !== 1'b1 || fault !== 1'b1 || ir !== 32'h0) begin
      fails++;
      $display("FAIL timeout: got req_cycles=%0d ready=%b fault=%b ir=%h, required 4 1 1 00000000", n, ready, fault, ir);
    end
    tick;
    tick;
  endtask

  task automatic test_branch_resp;
    ack = 1'b1; rdata = 32'h55AA55AA;
    tick;
    ack = 1'b0; branch = 1'b1;
    #1;
    tests++;
    if (ready !== 1'b0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL branch_resp: got ready=%b fault=%b, required 0 0", ready, fault);
    end
    tick;
    branch = 1'b0;
    tick;
    ack = 1'b1; branch = 1'b1;
    tick;
    ack = 1'b0; branch = 1'b0;
    tests++;
    if (req !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL branch_ack: got req=%b ready=%b, required 0 0", req, ready);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    tests++;
    if (req !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: got req=%b, required 1", req);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (req !== 1'b0 || ir !== 32'h0) begin
      fails++;
      $display("FAIL reset_async: got req=%b ir=%h, required 0 00000000", req, ir);
    end
    ack = 1'b1;
    tick;
    tick;
    tests++;
    if (req !== 1'b0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ack_ignored: got req=%b ready=%b, required 0 0", req, ready);
    end
    ack = 1'b0; rst = 1'b0; pc = 32'h300;
    tick;
    tests++;
    if (req !== 1'b1 || addr !== 32'h300) begin
      fails++;
      $display("FAIL reset_restart: got req=%b addr=%h, required 1 00000300", req, addr);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_branch;
    test_error;
    test_timeout;
    test_branch_resp;
    test_reset_mid;
    tick;
    tick;
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
